// File: rtl/lif_fxp_div_if.sv
// Handshake bundle for the LIF fixed-point divider: operand request side and
// result response side, each with its own valid/ready pair.
interface lif_fxp_div_if #(
  parameter int ACC_BITS = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [ACC_BITS-1:0] num;
  logic [ACC_BITS-1:0] den;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_BITS-1:0] quot;
  logic                sat;
  logic                div0;

  modport master (
    output in_valid, num, den, out_ready,
    input  in_ready, out_valid, quot, sat, div0
  );

  modport slave (
    input  in_valid, num, den, out_ready,
    output in_ready, out_valid, quot, sat, div0
  );
endinterface

// File: rtl/lif_fxp_div.sv
// Sequential restoring radix-2 signed fixed-point divider:
// quot = (num << FRAC_BITS) / den, truncated toward zero and saturated.
module lif_fxp_div #(
  parameter int ACC_BITS  = 8,
  parameter int FRAC_BITS = 6
) (
  input  logic            clk,
  input  logic            rst,
  lif_fxp_div_if.slave    bus
);

  localparam int N  = ACC_BITS + FRAC_BITS;
  localparam int CW = $clog2(N + 1);

  localparam logic [N-1:0]        MAX_MAG = N'((1 << (ACC_BITS - 1)) - 1);
  localparam logic [N-1:0]        MIN_MAG = N'(1 << (ACC_BITS - 1));
  localparam logic [ACC_BITS-1:0] MAX_POS = ACC_BITS'((1 << (ACC_BITS - 1)) - 1);
  localparam logic [ACC_BITS-1:0] MIN_NEG = ACC_BITS'(1 << (ACC_BITS - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;

  // r_dq starts as the dividend magnitude and fills with quotient bits from the LSB.
  logic [N-1:0]        r_dq;
  logic [ACC_BITS:0]   r_rem;
  logic [ACC_BITS:0]   r_den_mag;
  logic                r_sign;
  logic [CW-1:0]       r_cnt;
  logic [ACC_BITS-1:0] r_quot;
  logic                r_sat;
  logic                r_div0;

  logic [ACC_BITS-1:0] w_num_mag;
  logic [ACC_BITS:0]   w_den_ext;
  logic [ACC_BITS:0]   w_den_mag;
  logic                w_den_zero;
  logic [N-1:0]        w_dvd_init;
  logic [ACC_BITS+1:0] w_rem_sh;
  logic [ACC_BITS+1:0] w_diff;
  logic                w_qbit;
  logic [ACC_BITS:0]   w_rem_next;
  logic [N-1:0]        w_quo_next;
  logic                w_last;
  logic [ACC_BITS-1:0] w_res_quot;
  logic                w_res_sat;

  // Unsigned magnitude of the most negative value (e.g. -128 -> 128) still fits.
  assign w_num_mag  = bus.num[ACC_BITS-1] ? -bus.num : bus.num;
  assign w_den_ext  = {bus.den[ACC_BITS-1], bus.den};
  assign w_den_mag  = w_den_ext[ACC_BITS] ? -w_den_ext : w_den_ext;
  assign w_den_zero = (bus.den == '0);
  assign w_dvd_init = N'(w_num_mag) << FRAC_BITS;

  assign w_rem_sh   = {r_rem, r_dq[N-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_den_mag};
  assign w_qbit     = ~w_diff[ACC_BITS+1];
  assign w_rem_next = w_qbit ? w_diff[ACC_BITS:0] : w_rem_sh[ACC_BITS:0];
  assign w_quo_next = {r_dq[N-2:0], w_qbit};
  assign w_last     = (r_cnt == CW'(1));

  always_comb begin
    w_res_quot = '0;
    w_res_sat  = 1'b0;
    if (!r_sign) begin
      if (w_quo_next > MAX_MAG) begin
        w_res_quot = MAX_POS;
        w_res_sat  = 1'b1;
      end else begin
        w_res_quot = w_quo_next[ACC_BITS-1:0];
      end
    end else begin
      if (w_quo_next > MIN_MAG) begin
        w_res_quot = MIN_NEG;
        w_res_sat  = 1'b1;
      end else begin
        w_res_quot = -w_quo_next[ACC_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = w_den_zero ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dq      <= '0;
      r_rem     <= '0;
      r_den_mag <= '0;
      r_sign    <= 1'b0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_sat     <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_dq      <= w_dvd_init;
            r_rem     <= '0;
            r_den_mag <= w_den_mag;
            r_sign    <= bus.num[ACC_BITS-1] ^ bus.den[ACC_BITS-1];
            r_cnt     <= CW'(N);
            if (w_den_zero) begin
              r_quot <= bus.num[ACC_BITS-1] ? MIN_NEG : MAX_POS;
              r_sat  <= 1'b1;
              r_div0 <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_dq  <= w_quo_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_quot <= w_res_quot;
            r_sat  <= w_res_sat;
            r_div0 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quot = r_quot;
  assign bus.sat  = r_sat;
  assign bus.div0 = r_div0;

endmodule

// File: tb/tb_lif_fxp_div.sv
// Scoreboard bench for lif_fxp_div: the driver queues expected results, a
// monitor compares them whenever the divider hands a result over.
module tb_lif_fxp_div;

  localparam int A    = 8;
  localparam int F    = 6;
  localparam int N    = A + F;
  localparam int MAXV = (1 << (A - 1)) - 1;
  localparam int MINV = -(1 << (A - 1));

  typedef struct {
    int quot;
    int sat;
    int div0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lif_fxp_div_if #(.ACC_BITS(A)) bus ();

  lif_fxp_div #(.ACC_BITS(A), .FRAC_BITS(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q_exp[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int q, input int s, input int z);
    exp_t e;
    e.quot = q;
    e.sat  = s;
    e.div0 = z;
    return e;
  endfunction

  // Plain-arithmetic reference: magnitudes divided, sign reapplied, then clamped.
  function automatic exp_t model(input int n, input int d);
    exp_t   e;
    longint mag;
    longint s;
    if (d == 0) return mk((n < 0) ? MINV : MAXV, 1, 1);
    mag = (longint'(n < 0 ? -n : n) * (longint'(1) << F)) / longint'(d < 0 ? -d : d);
    s   = ((n < 0) != (d < 0)) ? -mag : mag;
    if (s > MAXV)      e = mk(MAXV, 1, 0);
    else if (s < MINV) e = mk(MINV, 1, 0);
    else               e = mk(int'(s), 0, 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("ready_valid_exclusive", bus.in_ready & bus.out_valid, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q_exp.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = q_exp.pop_front();
          check("quot", $signed(bus.quot), mon_e.quot);
          check("sat",  bus.sat,  mon_e.sat);
          check("div0", bus.div0, mon_e.div0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one time unit after the accepting edge.
  task automatic send(input int n, input int d, input exp_t e);
    bit ok;
    ok           = 1'b0;
    bus.num      = A'(n);
    bus.den      = A'(d);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    q_exp.push_back(e);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  int dn[15] = '{ 32,  48,  16, -16,  -32, -128,  64,  -64, -128,   5,   -5,   0,  0, 127,   1};
  int dd[15] = '{ 64,  32,  48,  48,   16, -128,  16,   16,    1,   0,    0,   0, -7,   1, 127};
  int dq[15] = '{ 32,  96,  21, -21, -128,   64, 127, -128, -128, 127, -128, 127,  0, 127,   0};
  int ds[15] = '{  0,   0,   0,   0,    0,    0,   1,    1,    1,   1,    1,   1,  0,   1,   0};
  int dz[15] = '{  0,   0,   0,   0,    0,    0,   0,    0,    0,   1,    1,   1,  0,   0,   0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int d;
    int sel;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.num       = '0;
    bus.den       = '0;
    #12;
    check("reset_in_ready",  bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_quot",      $signed(bus.quot), 0);
    check("reset_sat",       bus.sat, 0);
    check("reset_div0",      bus.div0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed table from the fixed-point test points; div-by-zero is visible right after acceptance.
    for (int i = 0; i < 15; i++) begin
      send(dn[i], dd[i], mk(dq[i], ds[i], dz[i]));
      wait_valid(lat);
      check("latency", lat, (dd[i] == 0) ? 0 : N);
      take();
    end

    // Backpressure: result held for 10 cycles while a new pair waits upstream.
    send(48, 32, mk(96, 0, 0));
    wait_valid(lat);
    check("bp_latency", lat, N);
    bus.num      = A'(10);
    bus.den      = A'(20);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_quot",      $signed(bus.quot), 96);
      check("bp_sat",       bus.sat, 0);
      check("bp_div0",      bus.div0, 0);
      check("bp_in_ready",  bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
    end
    take();
    check("bp_idle_after_release", bus.in_ready, 1);
    send(10, 20, mk(32, 0, 0));
    wait_valid(lat);
    check("bp_next_latency", lat, N);
    take();

    // Asynchronous reset in the middle of CALC.
    send(100, 3, mk(127, 1, 0));
    repeat (6) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready",  bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_quot",      $signed(bus.quot), 0);
    check("midrst_sat",       bus.sat, 0);
    q_exp.delete();
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) tick();
    check("midrst_no_stale", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    send(32, 64, mk(32, 0, 0));
    wait_valid(lat);
    check("midrst_fresh_latency", lat, N);
    take();

    // Randomised operands with random consumer stalls.
    for (int i = 0; i < 60; i++) begin
      n   = int'($urandom_range(0, 255)) - 128;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      d = 0;
      else if (sel == 1) d = -128;
      else if (sel == 2) d = ($urandom_range(0, 1) != 0) ? 1 : -1;
      else               d = int'($urandom_range(0, 255)) - 128;
      if (sel == 3) n = -128;
      send(n, d, model(n, d));
      wait_valid(lat);
      check("rand_latency", lat, (d == 0) ? 0 : N);
      repeat ($urandom_range(0, 3)) tick();
      take();
    end

    repeat (5) tick();
    check("scoreboard_empty", q_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
